vedic3bit_mac: RTL and testbench

- Sequential multiply-accumulate stage directly downstream of the 3-bit Vedic multiplier.
- Accepts a stream of 3-bit operand pairs over a valid/ready handshake and multiplies each pair with an internal vedic3bit instance.
- Sums the 6-bit products of one vector, where a vector ends on the beat flagged in_last.
- Presents the dot-product result, term count and overflow flag on a valid/ready output handshake.

---
 rtl/vedic_pkg.sv | 23 ++
 rtl/vedic3bit.sv | 34 +++
 rtl/vedic3bit_mac.sv | 154 +++++++++++++++
 tb/tb_vedic3bit_mac.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the 3-bit Vedic multiplier and the multiply-accumulate
// stage built on it.
//   OP_W      : operand width of the multiplier (3)
//   PROD_W    : product width of the multiplier (6)
//   ACC_W_DEF : default accumulator/result width
//   CNT_W_DEF : default term-counter width
//   mac_state_t : result-handshake states (ACCUM, HOLD)
// -----------------------------------------------------------------------------
package vedic_pkg;

  localparam int OP_W      = 3;
  localparam int PROD_W    = 6;
  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;

endpackage

// File: rtl/vedic3bit.sv
// -----------------------------------------------------------------------------
// vedic3bit
// Combinational 3x3 unsigned multiplier using the Urdhva Tiryagbhyam
// (vertically-and-crosswise) column scheme.
// Ports:
//   A   : input  [2:0] multiplicand
//   B   : input  [2:0] multiplier
//   mul : output [5:0] unsigned product A*B
// -----------------------------------------------------------------------------
module vedic3bit
  import vedic_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] mul
);

  // Each column sums its crosswise partial products plus the carry bits
  // handed up from the column below; bit 0 of each column sum is a product bit.
  logic [1:0] w_s1;
  logic [2:0] w_s2;
  logic [2:0] w_s3;
  logic [1:0] w_s4;

  assign w_s1 = {1'b0, A[1] & B[0]} + {1'b0, A[0] & B[1]};
  assign w_s2 = {2'b00, A[2] & B[0]} + {2'b00, A[1] & B[1]}
              + {2'b00, A[0] & B[2]} + {2'b00, w_s1[1]};
  assign w_s3 = {2'b00, A[2] & B[1]} + {2'b00, A[1] & B[2]}
              + {1'b0, w_s2[2:1]};
  assign w_s4 = {1'b0, A[2] & B[2]} + w_s3[2:1];

  assign mul = {w_s4, w_s3[0], w_s2[0], w_s1[0], A[0] & B[0]};

endmodule

// File: rtl/vedic3bit_mac.sv
// -----------------------------------------------------------------------------
// vedic3bit_mac
// Multiply-accumulate stage behind the 3-bit Vedic multiplier. Operand pairs
// arrive on a valid/ready stream; each product is summed into an accumulator
// until the beat flagged in_last, then the dot product, term count and an
// overflow flag are held on a valid/ready result port.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b          : 3-bit operands
//   in_last             : final beat of the current vector
//   out_valid/out_ready : result handshake
//   out_acc             : ACC_W-bit sum of the vector's products
//   out_cnt             : CNT_W-bit beat count (saturating)
//   out_ovf             : accumulator carried out during the vector
// Build option:
//   VEDIC_MAC_SAT_EN : when defined the accumulator saturates to 2^ACC_W-1 on
//                      carry instead of wrapping; handshake timing is unchanged.
// -----------------------------------------------------------------------------
module vedic3bit_mac
  import vedic_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] s);
`ifdef VEDIC_MAC_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  mac_state_t        r_state;
  mac_state_t        w_state_next;

  logic [PROD_W-1:0] w_prod;
  logic              w_accept;

  logic [PROD_W-1:0] r_prod_p1;
  logic              r_vld_p1;
  logic              r_last_p1;

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [ACC_W-1:0]  r_out_acc;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_out_ovf;

  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_cnt_next;

  vedic3bit u_mul (
    .A   (in_a),
    .B   (in_b),
    .mul (w_prod)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_prod_p1};
  assign w_carry    = w_sum[ACC_W];
  assign w_acc_next = acc_limit(w_sum);
  assign w_cnt_next = cnt_inc(r_cnt);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: if (r_vld_p1 && r_last_p1) w_state_next = HOLD;
      HOLD:  if (out_ready)             w_state_next = ACCUM;
      default:                          w_state_next = ACCUM;
    endcase
  end

  // FSM: outputs. Input stalls while a result is held and while the closing
  // product is still in the product stage, so a vector never overlaps its
  // own result.
  always_comb begin
    out_valid = (r_state == HOLD);
    in_ready  = (r_state != HOLD) && !(r_vld_p1 && r_last_p1);
  end

  // Stage 1 boundary: registered product of the accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_prod_p1 <= w_prod;
        r_last_p1 <= in_last;
      end
    end
  end

  // Stage 2 boundary: running sum, and the held result on the closing product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_acc <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else if (r_vld_p1) begin
      if (r_last_p1) begin
        r_out_acc <= w_acc_next;
        r_out_cnt <= w_cnt_next;
        r_out_ovf <= r_ovf | w_carry;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_acc     <= w_acc_next;
        r_cnt     <= w_cnt_next;
        r_ovf     <= r_ovf | w_carry;
      end
    end
  end

  assign out_acc = r_out_acc;
  assign out_cnt = r_out_cnt;
  assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_vedic3bit_mac.sv
`timescale 1ns/1ps
module tb_vedic3bit_mac;

  // Two instances share the stimulus: a default-width one, and a narrow one
  // (ACC_W=6, CNT_W=2) that exercises accumulator overflow and count saturation.
  localparam int AW_A = 12;
  localparam int CW_A = 8;
  localparam int AW_B = 6;
  localparam int CW_B = 2;
`ifdef VEDIC_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] in_a = 3'd0;
  logic [2:0] in_b = 3'd0;

  logic rdy_a, rdy_b, ov_a, ov_b, of_a, of_b;
  logic [AW_A-1:0] acc_a;
  logic [CW_A-1:0] cnt_a;
  logic [AW_B-1:0] acc_b;
  logic [CW_B-1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vedic3bit_mac #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_cnt(cnt_a), .out_ovf(of_a)
  );

  vedic3bit_mac #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_cnt(cnt_b), .out_ovf(of_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models dut_a, index 1 models dut_b. Sums are plain integers;
  // width limits are applied as wrap (modulo) or clamp (min).
  int  aw [2] = '{AW_A, AW_B};
  int  cw [2] = '{CW_A, CW_B};
  int  m_prod = 0;
  bit  m_pv = 0, m_plast = 0, m_ov = 0;
  int  m_acc [2] = '{0, 0};
  int  m_cnt [2] = '{0, 0};
  bit  m_ovf [2] = '{0, 0};
  int  m_oacc[2] = '{0, 0};
  int  m_ocnt[2] = '{0, 0};
  bit  m_oovf[2] = '{0, 0};

  function automatic bit m_ready();
    return !m_ov && !(m_pv && m_plast);
  endfunction

  always @(posedge clk) begin
    bit take;
    int s, lim, cmax, nacc, ncnt;
    bit c;
    take = in_valid && m_ready();
    if (rst) begin
      m_pv = 0; m_plast = 0; m_ov = 0; m_prod = 0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        m_oacc[k] = 0; m_ocnt[k] = 0; m_oovf[k] = 0;
      end
    end else begin
      if (m_ov && out_ready) m_ov = 0;
      if (m_pv) begin
        for (int k = 0; k < 2; k++) begin
          lim  = 1 << aw[k];
          cmax = (1 << cw[k]) - 1;
          s    = m_acc[k] + m_prod;
          c    = (s >= lim);
          nacc = c ? (SAT ? lim - 1 : s - lim) : s;
          ncnt = (m_cnt[k] + 1 > cmax) ? cmax : m_cnt[k] + 1;
          if (m_plast) begin
            m_oacc[k] = nacc; m_ocnt[k] = ncnt; m_oovf[k] = m_ovf[k] | c;
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
          end else begin
            m_acc[k] = nacc; m_cnt[k] = ncnt; m_ovf[k] = m_ovf[k] | c;
          end
        end
        if (m_plast) m_ov = 1;
      end
      m_pv = take;
      if (take) begin
        m_prod  = int'(in_a) * int'(in_b);
        m_plast = in_last;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready_a",  int'(rdy_a), int'(m_ready()));
      chk("in_ready_b",  int'(rdy_b), int'(m_ready()));
      chk("out_valid_a", int'(ov_a),  int'(m_ov));
      chk("out_valid_b", int'(ov_b),  int'(m_ov));
      chk("out_acc_a",   int'(acc_a), m_oacc[0]);
      chk("out_cnt_a",   int'(cnt_a), m_ocnt[0]);
      chk("out_ovf_a",   int'(of_a),  int'(m_oovf[0]));
      chk("out_acc_b",   int'(acc_b), m_oacc[1]);
      chk("out_cnt_b",   int'(cnt_b), m_ocnt[1]);
      chk("out_ovf_b",   int'(of_b),  int'(m_oovf[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input int a, input int b, input bit last);
    bit done;
    done = 0;
    in_a = 3'(a); in_b = 3'(b); in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (rdy_a) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat (%0d,%0d) not accepted, in_ready=%0d", a, b, rdy_a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a result, check it against literals, then let the
  // handshake edge pass (when out_ready is high).
  task automatic expect_result(input string tag,
                               input int ea, input int ec, input int eo,
                               input int eb, input int ecb, input int eob);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ov_a) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid=0, expected 1", tag);
    end else begin
      chk({tag, "_acc_a"}, int'(acc_a), ea);
      chk({tag, "_cnt_a"}, int'(cnt_a), ec);
      chk({tag, "_ovf_a"}, int'(of_a),  eo);
      chk({tag, "_acc_b"}, int'(acc_b), eb);
      chk({tag, "_cnt_b"}, int'(cnt_b), ecb);
      chk({tag, "_ovf_b"}, int'(of_b),  eob);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int sb_acc;
    int ov_acc;
    sb_acc = SAT ? 63 : 38;
    ov_acc = SAT ? 63 : 34;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", int'(rdy_a), 1);
    chk("rst_out_valid", int'(ov_a), 0);
    chk("rst_out_acc", int'(acc_a), 0);
    chk("rst_out_cnt", int'(cnt_a), 0);
    @(posedge clk); #1;

    // Streaming vector: 2+8+20+30+42 = 102; narrow copy carries at 102
    send(1, 2, 0); send(2, 4, 0); send(4, 5, 0); send(5, 6, 0); send(6, 7, 1);
    @(negedge clk);
    chk("lat_c1_valid", int'(ov_a), 0);
    chk("lat_c1_ready", int'(rdy_a), 0);
    @(negedge clk);
    chk("lat_c2_valid", int'(ov_a), 1);
    chk("lat_c2_ready", int'(rdy_a), 0);
    chk("stream_acc_a", int'(acc_a), 102);
    chk("stream_cnt_a", int'(cnt_a), 5);
    chk("stream_ovf_a", int'(of_a), 0);
    chk("stream_acc_b", int'(acc_b), sb_acc);
    chk("stream_cnt_b", int'(cnt_b), 3);
    chk("stream_ovf_b", int'(of_b), 1);
    @(negedge clk);
    chk("gap_ready", int'(rdy_a), 1);
    chk("gap_valid", int'(ov_a), 0);
    @(posedge clk); #1;

    // Single-beat vectors
    send(7, 7, 1);
    expect_result("single49", 49, 1, 0, 49, 1, 0);
    send(0, 5, 1);
    expect_result("single0", 0, 1, 0, 0, 1, 0);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    send(3, 3, 1);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (ov_a) seen = 1;
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL bp_timeout: out_valid=0, expected 1");
      end
    end
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", int'(ov_a), 1);
      chk("bp_acc", int'(acc_a), 9);
      chk("bp_ready", int'(rdy_a), 0);
      if (n < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", int'(rdy_a), 1);
    chk("bp_release_valid", int'(ov_a), 0);
    @(posedge clk); #1;

    // Overflow: 49+49 = 98; narrow copy wraps to 34 (or clamps to 63)
    send(7, 7, 0); send(7, 7, 1);
    expect_result("ovf", 98, 2, 0, ov_acc, 2, 1);

    // Reset mid-vector discards the partial sum
    send(5, 5, 0); send(6, 6, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(ov_a), 0);
    chk("midrst_ready", int'(rdy_a), 1);
    @(posedge clk); #1;
    send(2, 3, 1);
    expect_result("midrst", 6, 1, 0, 6, 1, 0);

    // Input gaps: 1+4+9 = 14
    send(1, 1, 0); idle(3); send(2, 2, 0); idle(1); send(3, 3, 1);
    expect_result("gaps", 14, 3, 0, 14, 3, 0);

    idle(3);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
